// File: rtl/systolic_sequencer_if.sv
// Command, operand-buffer and array-feed signals of the systolic sequencer.
// master = command logic / operand buffers / consumer, slave = sequencer.
interface systolic_sequencer_if #(
  parameter int SIZE   = 4,
  parameter int DATA_W = 8,
  parameter int K_W    = 8
);
  logic                     start;
  logic [K_W-1:0]           k_len;
  logic                     busy;
  logic                     rd_en;
  logic [K_W-1:0]           rd_addr;
  logic [SIZE*DATA_W-1:0]   a_data;
  logic [SIZE*DATA_W-1:0]   b_data;
  logic [SIZE*DATA_W-1:0]   a_rows;
  logic [SIZE*DATA_W-1:0]   b_cols;
  logic [SIZE-1:0]          lane_valid;
  logic                     acc_clear;
  logic                     res_valid;
  logic                     res_ready;
  logic                     done;

  modport master (
    output start, k_len, a_data, b_data, res_ready,
    input  busy, rd_en, rd_addr, a_rows, b_cols, lane_valid, acc_clear, res_valid, done
  );

  modport slave (
    input  start, k_len, a_data, b_data, res_ready,
    output busy, rd_en, rd_addr, a_rows, b_cols, lane_valid, acc_clear, res_valid, done
  );
endinterface

// File: rtl/systolic_sequencer.sv
// Sequences one matrix-multiply pass: clear, feed K operand vectors with
// per-lane skew, flush until PE(SIZE-1,SIZE-1) has accumulated, then hand off.
module systolic_skew_lane #(
  parameter int DATA_W = 8,
  parameter int STAGES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vld_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              vld_out,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out
);
  logic [STAGES-1:0]             vld_pipe;
  logic [STAGES-1:0][DATA_W-1:0] a_pipe, b_pipe;

  // Stage 0 is the capture register; invalid slots are zeroed so the
  // array accumulates nothing from them.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      a_pipe   <= '0;
      b_pipe   <= '0;
    end else begin
      vld_pipe[0] <= vld_in;
      a_pipe[0]   <= vld_in ? a_in : '0;
      b_pipe[0]   <= vld_in ? b_in : '0;
      for (int s = 1; s < STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        a_pipe[s]   <= a_pipe[s-1];
        b_pipe[s]   <= b_pipe[s-1];
      end
    end
  end

  assign vld_out = vld_pipe[STAGES-1];
  assign a_out   = a_pipe[STAGES-1];
  assign b_out   = b_pipe[STAGES-1];
endmodule

module systolic_sequencer #(
  parameter int SIZE   = 4,
  parameter int DATA_W = 8,
  parameter int K_W    = 8
) (
  input  logic                clock,
  input  logic                reset,
  systolic_sequencer_if.slave bus
);
  localparam int FL_W = $clog2(2*SIZE);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, RESULT} state_t;

  state_t          state, state_nxt;
  logic [K_W-1:0]  k_lat;
  logic [K_W-1:0]  addr;
  logic [FL_W-1:0] flush_cnt;
  logic            rd_en_d;
  logic            rd_en, acc_clear, res_valid, done;

  logic [SIZE-1:0]             lane_valid;
  logic [SIZE-1:0][DATA_W-1:0] a_rows, b_cols;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      k_lat     <= '0;
      addr      <= '0;
      flush_cnt <= '0;
      rd_en_d   <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_en_d <= rd_en;
      if (state == IDLE && state_nxt == CLEAR) k_lat <= bus.k_len;
      // Address only advances inside FEED, so it never wraps even for K = 2^K_W-1.
      addr      <= (state == FEED && state_nxt == FEED) ? addr + K_W'(1) : '0;
      flush_cnt <= (state == FLUSH) ? flush_cnt + FL_W'(1) : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    acc_clear = 1'b0;
    res_valid = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:   if (bus.start && bus.k_len != '0) state_nxt = CLEAR;
      CLEAR: begin
        acc_clear = 1'b1;
        state_nxt = FEED;
      end
      FEED: begin
        rd_en = 1'b1;
        if (addr == k_lat - K_W'(1)) state_nxt = FLUSH;
      end
      // Last element needs 2 + 2*(SIZE-1) cycles to reach the far corner PE.
      FLUSH:  if (flush_cnt == FL_W'(2*SIZE-1)) state_nxt = RESULT;
      RESULT: begin
        res_valid = 1'b1;
        if (bus.res_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    systolic_skew_lane #(.DATA_W(DATA_W), .STAGES(i+1)) u_lane (
      .clock   (clock),
      .reset   (reset),
      .vld_in  (rd_en_d),
      .a_in    (bus.a_data[i*DATA_W +: DATA_W]),
      .b_in    (bus.b_data[i*DATA_W +: DATA_W]),
      .vld_out (lane_valid[i]),
      .a_out   (a_rows[i]),
      .b_out   (b_cols[i])
    );
  end

  assign bus.busy       = (state != IDLE);
  assign bus.rd_en      = rd_en;
  assign bus.rd_addr    = addr;
  assign bus.acc_clear  = acc_clear;
  assign bus.res_valid  = res_valid;
  assign bus.done       = done;
  assign bus.lane_valid = lane_valid;
  assign bus.a_rows     = a_rows;
  assign bus.b_cols     = b_cols;
endmodule

// File: tb/tb_systolic_sequencer.sv
// Randomized bench: pass-schedule reference model plus a behavioural MAC
// array whose results are compared with the plain matrix product.
module tb_systolic_sequencer;
  localparam int SIZE = 4, DATA_W = 8, K_W = 8, LW = SIZE*DATA_W;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  systolic_sequencer_if #(.SIZE(SIZE), .DATA_W(DATA_W), .K_W(K_W)) sif ();

  systolic_sequencer #(.SIZE(SIZE), .DATA_W(DATA_W), .K_W(K_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (sif)
  );

  int errors = 0, checks = 0;
  logic [DATA_W-1:0] mem_a [256][SIZE];
  logic [DATA_W-1:0] mem_b [256][SIZE];

  // Pass-schedule model: a pass accepted at cycle p_s with length p_k.
  int   cyc = 0, p_s = 0, p_k = 0;
  bit   have_pass = 0, prev_rv = 0, rv_now = 0;
  logic prev_rd = 0;
  logic [K_W-1:0] prev_addr = '0;

  // Behavioural array: PE(i,j) sees row i delayed j cycles, column j delayed i.
  logic [DATA_W-1:0] ha [SIZE][SIZE];
  logic [DATA_W-1:0] hb [SIZE][SIZE];
  int acc [SIZE][SIZE];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] pack_a(input int a);
    logic [LW-1:0] r;
    for (int i = 0; i < SIZE; i++) r[i*DATA_W +: DATA_W] = mem_a[a][i];
    return r;
  endfunction

  function automatic logic [LW-1:0] pack_b(input int a);
    logic [LW-1:0] r;
    for (int i = 0; i < SIZE; i++) r[i*DATA_W +: DATA_W] = mem_b[a][i];
    return r;
  endfunction

  task automatic step(input logic st, input logic [K_W-1:0] k, input logic rdy, input logic rs);
    int d, kk, e;
    logic e_busy, e_rd, e_clr, e_rv, e_done;
    logic [K_W-1:0] e_addr;
    logic [SIZE-1:0] e_lv;
    logic [LW-1:0] e_a, e_b;
    @(posedge clock); #1;
    cyc++;
    // Operand buffers: registered read, garbage when not reading.
    sif.a_data    = prev_rd ? pack_a(int'(prev_addr)) : LW'($urandom());
    sif.b_data    = prev_rd ? pack_b(int'(prev_addr)) : LW'($urandom());
    sif.start     = st;
    sif.k_len     = k;
    sif.res_ready = rdy;
    reset         = rs;
    {e_busy, e_rd, e_clr, e_rv, e_done} = '0;
    e_addr = '0; e_lv = '0; e_a = '0; e_b = '0;
    d = cyc - p_s;
    if (have_pass) begin
      e_busy = (d >= 1);
      e_clr  = (d == 1);
      e_rd   = (d >= 2 && d < 2 + p_k);
      if (e_rd) e_addr = K_W'(d - 2);
      e_rv   = (d >= 2 + p_k + 2*SIZE);
      e_done = e_rv && rdy;
      for (int i = 0; i < SIZE; i++) begin
        kk = d - 4 - i;
        if (kk >= 0 && kk < p_k) begin
          e_lv[i] = 1'b1;
          e_a[i*DATA_W +: DATA_W] = mem_a[kk][i];
          e_b[i*DATA_W +: DATA_W] = mem_b[kk][i];
        end
      end
    end
    @(negedge clock);
    chk("busy", sif.busy, e_busy);
    chk("rd_en", sif.rd_en, e_rd);
    chk("rd_addr", sif.rd_addr, e_addr);
    chk("acc_clear", sif.acc_clear, e_clr);
    chk("res_valid", sif.res_valid, e_rv);
    chk("done", sif.done, e_done);
    chk("lane_valid", sif.lane_valid, e_lv);
    chk("a_rows", sif.a_rows, e_a);
    chk("b_cols", sif.b_cols, e_b);
    if (e_rv && !prev_rv) begin
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++) begin
          e = 0;
          for (int t = 0; t < p_k; t++) e += int'(mem_a[t][i]) * int'(mem_b[t][j]);
          chk($sformatf("c_%0d_%0d", i, j), acc[i][j], e);
        end
    end
    prev_rv = e_rv;
    rv_now  = e_rv;
    if (sif.acc_clear)
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++) begin
          acc[i][j] = 0; ha[i][j] = '0; hb[i][j] = '0;
        end
    for (int t = SIZE-1; t > 0; t--)
      for (int l = 0; l < SIZE; l++) begin
        ha[t][l] = ha[t-1][l];
        hb[t][l] = hb[t-1][l];
      end
    for (int l = 0; l < SIZE; l++) begin
      ha[0][l] = sif.a_rows[l*DATA_W +: DATA_W];
      hb[0][l] = sif.b_cols[l*DATA_W +: DATA_W];
    end
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        acc[i][j] += int'(ha[j][i]) * int'(hb[i][j]);
    prev_rd   = sif.rd_en;
    prev_addr = sif.rd_addr;
    if (rs || e_done) have_pass = 0;
    else if (!have_pass && st && k != '0) begin
      have_pass = 1; p_s = cyc; p_k = int'(k);
    end
  endtask

  // One pass: hold res_ready low for `hold` RESULT cycles; noise 1 = random
  // starts during the pass, 2 = start asserted on every cycle of the pass.
  task automatic run_pass(input int k, input int hold, input int noise);
    int g, rv_seen;
    logic st;
    g = 0; rv_seen = 0;
    step(1'b1, K_W'(k), hold == 0, 1'b0);
    chk("accepted", have_pass, 1);
    while (have_pass) begin
      st = (noise == 2) || (noise == 1 && $urandom_range(0, 3) == 0);
      step(st, K_W'($urandom_range(1, 9)), rv_seen >= hold, 1'b0);
      if (rv_now) rv_seen++;
      g++;
      if (g > 3000) begin
        chk("pass_timeout", 1, 0);
        break;
      end
    end
    if (g <= 3000) chk("result_cycles", rv_seen, hold + 1);
  endtask

  task automatic rand_mem();
    for (int a = 0; a < 256; a++)
      for (int l = 0; l < SIZE; l++) begin
        mem_a[a][l] = DATA_W'($urandom());
        mem_b[a][l] = DATA_W'($urandom());
      end
  endtask

  initial begin
    sif.start = 0; sif.k_len = '0; sif.res_ready = 0;
    sif.a_data = '0; sif.b_data = '0;
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) begin
        acc[i][j] = 0; ha[i][j] = '0; hb[i][j] = '0;
      end
    rand_mem();
    repeat (2) @(posedge clock);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // K=3 timeline with res_ready high from the start.
    run_pass(3, 0, 0);
    step(0, 0, 0, 0);

    // Identity A times B = 1..16.
    for (int k = 0; k < 4; k++)
      for (int l = 0; l < SIZE; l++) begin
        mem_a[k][l] = (k == l) ? 8'd1 : 8'd0;
        mem_b[k][l] = DATA_W'(4*k + l + 1);
      end
    run_pass(4, 0, 0);
    for (int k = 0; k < 4; k++)
      for (int l = 0; l < SIZE; l++) begin
        mem_a[k][l] = 8'd2;
        mem_b[k][l] = 8'd3;
      end
    run_pass(4, 1, 0);

    // Back-pressure with start pulses during RESULT.
    rand_mem();
    run_pass(5, 10, 1);

    // k_len=0 start ignored.
    step(1, 0, 0, 0);
    chk("k0_idle", have_pass, 0);
    step(0, 0, 0, 0);

    // Start held through the done cycle, then accepted on the first IDLE cycle.
    run_pass(2, 0, 2);
    run_pass(3, 2, 0);

    // Reset during FEED abandons the pass.
    step(1, 3, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    repeat (12) step(0, 0, 1, 0);
    run_pass(3, 0, 0);

    // K=1 boundary and K=max.
    run_pass(1, 0, 0);
    rand_mem();
    run_pass(255, 3, 1);

    for (int p = 0; p < 15; p++) begin
      rand_mem();
      repeat ($urandom_range(0, 3)) step($urandom_range(0, 1), 0, 0, 0);
      run_pass($urandom_range(1, 24), $urandom_range(0, 5), $urandom_range(0, 2));
    end
    repeat (3) step(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
